branch_pht: RTL and testbench

// - Pattern history table of PHT_ENTRIES saturating counters; parametrised successor to the single 2-bit counter.
// - Sits in fetch; supplies a one-cycle taken/not-taken prediction per branch PC.
// - Trained at retire/resolve with the actual outcome.
// - Optional gshare indexing with a speculative global history register (GHR) and a mispredict restore path.

---
 rtl/branch_pht.sv | 91 +++++++++
 tb/tb_branch_pht.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/branch_pht.sv
// Pattern history table of saturating counters with optional gshare indexing.
// The prediction is combinational from the current GHR; training and GHR moves land at the next edge.
module branch_pht_ctr #(
  parameter int CTR_WIDTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic taken
);
  localparam logic [CTR_WIDTH-1:0] RST_VAL = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] MAX_VAL = '1;

  logic [CTR_WIDTH-1:0] ctr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        ctr <= RST_VAL;
    else if (inc && ctr != MAX_VAL)    ctr <= ctr + 1'b1;
    else if (dec && ctr != '0)         ctr <= ctr - 1'b1;
  end

  assign taken = ctr[CTR_WIDTH-1];
endmodule

module branch_pht #(
  parameter int PHT_ENTRIES = 64,
  parameter int CTR_WIDTH   = 2,
  parameter int GHR_WIDTH   = 6,
  parameter int GSHARE      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 predict_en,
  input  logic [31:0]          predict_pc,
  output logic                 pred_taken,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  input  logic                 update_en,
  input  logic [31:0]          update_pc,
  input  logic [GHR_WIDTH-1:0] update_ghr,
  input  logic                 update_taken,
  input  logic                 mispredict
);
  localparam int IDX_W = $clog2(PHT_ENTRIES);

  logic [GHR_WIDTH-1:0]   ghr;
  logic [GHR_WIDTH-1:0]   spec_hist, rest_hist;
  logic [IDX_W-1:0]       pred_idx, upd_idx;
  logic [PHT_ENTRIES-1:0] msb;
  logic                   unused_pc_bits;

  // Only the word-index bits of the PC select a counter.
  assign unused_pc_bits = ^{predict_pc[31:IDX_W+2], predict_pc[1:0],
                            update_pc[31:IDX_W+2], update_pc[1:0]};

  assign pred_idx = predict_pc[IDX_W+1:2] ^ ((GSHARE != 0) ? IDX_W'(ghr)        : '0);
  assign upd_idx  = update_pc[IDX_W+1:2]  ^ ((GSHARE != 0) ? IDX_W'(update_ghr) : '0);

  assign pred_taken = msb[pred_idx];
  assign pred_ghr   = ghr;

  for (genvar i = 0; i < PHT_ENTRIES; i++) begin : g_ent
    logic hit;
    assign hit = update_en && (upd_idx == IDX_W'(i));
    branch_pht_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_ctr (
      .clock (clock),
      .reset (reset),
      .inc   (hit &  update_taken),
      .dec   (hit & ~update_taken),
      .taken (msb[i])
    );
  end

  if (GHR_WIDTH == 1) begin : g_hist1
    logic unused_hist;
    assign unused_hist = ^update_ghr;
    assign spec_hist   = pred_taken;
    assign rest_hist   = update_taken;
  end else begin : g_histn
    assign spec_hist = {ghr[GHR_WIDTH-2:0], pred_taken};
    assign rest_hist = {update_ghr[GHR_WIDTH-2:0], update_taken};
  end

  // A resolved mispredict rebuilds history from the branch's own snapshot,
  // discarding any speculative shift from the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                       ghr <= '0;
    else if (update_en && mispredict) ghr <= rest_hist;
    else if (predict_en)              ghr <= spec_hist;
  end
endmodule

// File: tb/tb_branch_pht.sv
// Randomized and directed checks of three branch_pht configurations against an arithmetic reference model.
module tb_branch_pht;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        predict_en = 1'b0, update_en = 1'b0, update_taken = 1'b0, mispredict = 1'b0;
  logic [31:0] predict_pc = '0, update_pc = '0;
  logic [5:0]  update_ghr = '0;
  logic        pt0, pt1, pt2;
  logic [5:0]  pg0, pg1;
  logic [3:0]  pg2;

  always #5 clock = ~clock;

  branch_pht #(.PHT_ENTRIES(64), .CTR_WIDTH(2), .GHR_WIDTH(6), .GSHARE(1)) u_gs (
    .clock(clock), .reset(reset), .predict_en(predict_en), .predict_pc(predict_pc),
    .pred_taken(pt0), .pred_ghr(pg0), .update_en(update_en), .update_pc(update_pc),
    .update_ghr(update_ghr), .update_taken(update_taken), .mispredict(mispredict));

  branch_pht #(.PHT_ENTRIES(64), .CTR_WIDTH(2), .GHR_WIDTH(6), .GSHARE(0)) u_bm (
    .clock(clock), .reset(reset), .predict_en(predict_en), .predict_pc(predict_pc),
    .pred_taken(pt1), .pred_ghr(pg1), .update_en(update_en), .update_pc(update_pc),
    .update_ghr(update_ghr), .update_taken(update_taken), .mispredict(mispredict));

  branch_pht #(.PHT_ENTRIES(16), .CTR_WIDTH(3), .GHR_WIDTH(4), .GSHARE(0)) u_sm (
    .clock(clock), .reset(reset), .predict_en(predict_en), .predict_pc(predict_pc),
    .pred_taken(pt2), .pred_ghr(pg2), .update_en(update_en), .update_pc(update_pc),
    .update_ghr(update_ghr[3:0]), .update_taken(update_taken), .mispredict(mispredict));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference model: counters as plain integers, history as an integer mod 2^G.
  int ent[3] = '{64, 64, 16};
  int cw[3]  = '{2, 2, 3};
  int gw[3]  = '{6, 6, 4};
  int gs[3]  = '{1, 0, 0};
  int m_ctr[3][64];
  int m_ghr[3];

  function automatic int midx(int d, logic [31:0] pc, int h);
    int base;
    base = int'((pc >> 2) % ent[d]);
    return gs[d] != 0 ? (base ^ h) : base;
  endfunction

  function automatic int mpred(int d, logic [31:0] pc);
    return (m_ctr[d][midx(d, pc, m_ghr[d])] >= (1 << (cw[d] - 1))) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_ghr[d] = 0;
      for (int i = 0; i < 64; i++) m_ctr[d][i] = (1 << (cw[d] - 1)) - 1;
    end
  endtask

  function automatic logic [31:0] got_pt(int d);
    return d == 0 ? 32'(pt0) : d == 1 ? 32'(pt1) : 32'(pt2);
  endfunction

  function automatic logic [31:0] got_pg(int d);
    return d == 0 ? 32'(pg0) : d == 1 ? 32'(pg1) : 32'(pg2);
  endfunction

  task automatic compare(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s.pred%0d", tag, d), got_pt(d), 32'(mpred(d, predict_pc)));
      chk($sformatf("%s.ghr%0d", tag, d), got_pg(d), 32'(m_ghr[d]));
    end
  endtask

  // Drive at negedge, check combinational outputs, then advance the model at posedge.
  task automatic step(input logic pe, input logic [31:0] ppc, input logic ue,
                      input logic [31:0] upc, input logic [5:0] ug, input logic ut,
                      input logic mp, input string tag);
    int p[3];
    int i, mx, hm;
    @(negedge clock);
    predict_en = pe; predict_pc = ppc; update_en = ue; update_pc = upc;
    update_ghr = ug; update_taken = ut; mispredict = mp;
    #1 compare(tag);
    for (int d = 0; d < 3; d++) p[d] = mpred(d, ppc);
    @(posedge clock);
    for (int d = 0; d < 3; d++) begin
      hm = 1 << gw[d];
      mx = (1 << cw[d]) - 1;
      if (ue) begin
        i = midx(d, upc, int'(ug) % hm);
        if (ut) m_ctr[d][i] = (m_ctr[d][i] < mx) ? m_ctr[d][i] + 1 : mx;
        else    m_ctr[d][i] = (m_ctr[d][i] > 0)  ? m_ctr[d][i] - 1 : 0;
      end
      if (ue && mp)  m_ghr[d] = ((int'(ug) % hm) * 2 + int'(ut)) % hm;
      else if (pe)   m_ghr[d] = (m_ghr[d] * 2 + p[d]) % hm;
    end
  endtask

  task automatic idle(input logic [31:0] ppc, input string tag);
    step(1'b0, ppc, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, tag);
  endtask

  logic [31:0] r_pc, r_upc;

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Every index reads weakly not-taken out of reset.
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 32'(i * 4), 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, "rst_scan");
      chk("rst_pred", 32'(pt1), 32'd0);
    end
    chk("rst_ghr", 32'(pg0), 32'd0);

    // Saturation up then down at pc 0x40 (history stays zero).
    for (int k = 0; k < 3; k++) step(1'b0, 32'h40, 1'b1, 32'h40, 6'h0, 1'b1, 1'b0, "sat_up");
    idle(32'h40, "sat_up_chk");
    chk("sat_up_bm", 32'(pt1), 32'd1);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h40, 1'b1, 32'h40, 6'h0, 1'b0, 1'b0, "sat_dn");
    idle(32'h40, "sat_dn_chk");
    chk("sat_dn_bm", 32'(pt1), 32'd0);

    // Back at 00: one taken makes 01, then same-cycle update+predict sees pre-update value.
    step(1'b0, 32'h40, 1'b1, 32'h40, 6'h0, 1'b1, 1'b0, "to01");
    step(1'b0, 32'h40, 1'b1, 32'h40, 6'h0, 1'b1, 1'b0, "nobypass");
    chk("nobypass_bm", 32'(pt1), 32'd0);
    idle(32'h40, "nobypass_next");
    chk("nobypass_next_bm", 32'(pt1), 32'd1);

    // Speculative shifts then a mispredict restore that overrides a same-cycle predict.
    for (int k = 0; k < 3; k++) step(1'b1, 32'h80, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, "spec0");
    chk("spec0_ghr", 32'(pg0), 32'd0);
    step(1'b1, 32'h40, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, "spec1");
    step(1'b1, 32'h44, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, "spec2");
    step(1'b1, 32'h40, 1'b1, 32'h0, 6'b000101, 1'b1, 1'b1, "restore");
    #1 chk("restore_ghr", 32'(pg0), 32'b001011);
    idle(32'h40, "post_restore");
    // mispredict without update_en leaves history to the predict path
    step(1'b0, 32'h40, 1'b0, 32'h0, 6'b111111, 1'b1, 1'b1, "mp_noupd");
    idle(32'h40, "mp_noupd_chk");

    // 3-bit counters cap at 7; 0x40 and 0x80 alias in the 16-entry bimodal table.
    for (int k = 0; k < 10; k++) step(1'b0, 32'h80, 1'b1, 32'h40, 6'h0, 1'b1, 1'b0, "cap");
    for (int k = 0; k < 4; k++) step(1'b0, 32'h80, 1'b1, 32'h80, 6'h0, 1'b0, 1'b0, "cap_dn");
    idle(32'h80, "cap_chk");
    chk("cap_alias_sm", 32'(pt2), 32'd0);

    // Async reset while training and predicting.
    for (int k = 0; k < 3; k++) step(1'b1, 32'h40, 1'b1, 32'h40, 6'h0, 1'b1, 1'b0, "pre_rst");
    @(negedge clock);
    predict_en = 1'b1; predict_pc = 32'h40; update_en = 1'b1; update_pc = 32'h40;
    update_taken = 1'b1; mispredict = 1'b1; update_ghr = 6'h3f;
    #2 reset = 1'b0;
    model_reset();
    #1 compare("rst_async");
    chk("rst_async_ghr", 32'(pg0), 32'd0);
    @(posedge clock);
    #1 compare("rst_held");
    @(negedge clock);
    predict_en = 1'b0; update_en = 1'b0; mispredict = 1'b0;
    reset = 1'b1;
    idle(32'h40, "rst_release");
    chk("rst_release_bm", 32'(pt1), 32'd0);

    // Random traffic with a narrow index pool so updates and predictions collide.
    for (int n = 0; n < 3000; n++) begin
      r_pc  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      r_upc = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), r_pc, 1'($urandom_range(0, 2) != 0), r_upc,
           6'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
